// File: rtl/btn_pkg.sv
// btn_pkg: shared constants, width helper and edge-type enum for the
// button debounce/pulse block.
//   DB_CYCLES_DEF   default debounce length (stable samples to accept)
//   RPT_DELAY_DEF   default hold time before the first auto-repeat pulse
//   RPT_PERIOD_DEF  default spacing of subsequent auto-repeat pulses
//   btn_width(v)    bits needed to hold the value v (at least 1)
//   edge_t          accepted-edge classification for one channel
package btn_pkg;

    localparam int DB_CYCLES_DEF  = 16;
    localparam int RPT_DELAY_DEF  = 1024;
    localparam int RPT_PERIOD_DEF = 256;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_t;

    // Smallest w such that 2**w > v, i.e. a w-bit counter can reach v.
    function automatic int btn_width(input int v);
        int w;
        w = 1;
        while ((1 << w) <= v && w < 31)
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one input channel -- two-flop synchroniser, debounce
// counter, debounced level flop, registered rise/fall pulses and (with
// BTN_AUTO_REPEAT_EN defined) a hold counter that re-fires rise.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         enable; low freezes counter/level and blanks pulses
//   raw         asynchronous raw input
//   level       debounced level
//   rise, fall  one-cycle registered edge pulses
//   rise_nxt    next-cycle value of rise, for the top-level any_rise flop
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int DB_W       = btn_width(DB_CYCLES),
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt
);

    if (DB_CYCLES < 1 || (1 << DB_W) <= DB_CYCLES || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce_chan: illegal parameter set");
    end

    logic [1:0]      sync_q;
    logic            sync;
    logic [DB_W-1:0] cnt_q;
    logic            level_q;
    logic            accept;
    logic            rpt_hit;
    logic            fall_nxt;
    edge_t           edge_nxt;

    assign sync  = sync_q[1];
    assign level = level_q;

    // Synchroniser runs even with ena low so the chain is never stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], raw};
    end

    // Accept on the DB_CYCLES-th consecutive mismatching sample.
    assign accept = (sync != level_q) && (cnt_q == DB_W'(DB_CYCLES - 1));

    always_comb begin
        edge_nxt = EDGE_NONE;
        if (ena && accept)
            edge_nxt = sync ? EDGE_RISE : EDGE_FALL;
        rise_nxt = (edge_nxt == EDGE_RISE) || rpt_hit;
        fall_nxt = (edge_nxt == EDGE_FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= rise_nxt;
            fall <= fall_nxt;
            if (ena) begin
                if (sync == level_q) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    level_q <= sync;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = btn_width((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD);

    logic [RW-1:0] hold_q;
    logic          armed_q;   // first (long) delay already served
    logic [RW-1:0] rpt_lim;

    assign rpt_lim = armed_q ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1);
    // Suppressed on an accepting cycle so a release can never coincide
    // with a repeat rise on the same channel.
    assign rpt_hit = ena && level_q && !accept && (hold_q == rpt_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else if (!ena || !level_q) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else if (hold_q == rpt_lim) begin
            hold_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            hold_q <= hold_q + RW'(1);
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronises, debounces and edge-detects N_BTN raw
// button lines for the counter datapath.
// Optional feature: define BTN_AUTO_REPEAT_EN for held-button auto-repeat
// on btn_rise (RPT_DELAY first, then every RPT_PERIOD cycles).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         global enable; low freezes debounce state and blanks pulses
//   btn_raw     asynchronous raw inputs
//   btn_level   debounced levels
//   btn_rise    one-cycle pulse per accepted 0->1 (and per repeat)
//   btn_fall    one-cycle pulse per accepted 1->0
//   any_rise    registered OR of btn_rise, coincident with it
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int DB_W       = btn_width(DB_CYCLES),
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic             any_rise
);

    if (N_BTN < 1 || N_BTN > 8) begin : g_bad_nbtn
        $error("btn_debounce_pulse: N_BTN must be 1..8");
    end

    logic [N_BTN-1:0] rise_nxt;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .raw     (btn_raw[g]),
            .level   (btn_level[g]),
            .rise    (btn_rise[g]),
            .fall    (btn_fall[g]),
            .rise_nxt(rise_nxt[g])
        );
    end

    // Registered from the channels' next-state rise so it lines up with
    // btn_rise instead of trailing it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            any_rise <= 1'b0;
        else
            any_rise <= |rise_nxt;
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with N_BTN=4, DB_CYCLES=4,
// RPT_DELAY=8, RPT_PERIOD=3. Per-cycle vector table for the clean press
// and glitch boundary, hand sequences for reset, bounce, freeze, repeat.
module tb_btn_debounce_pulse;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ena     = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] btn_level, btn_rise, btn_fall;
    logic       any_rise;

    int n_tests = 0;
    int n_fail  = 0;

    btn_debounce_pulse #(
        .N_BTN     (4),
        .DB_CYCLES (4),
        .RPT_DELAY (8),
        .RPT_PERIOD(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .any_rise (any_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t tv[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clock edges; sample 1ns after the last one.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [3:0] raw,
                        input logic [3:0] lvl, input logic [3:0] rise, input logic any);
        for (int i = lo; i <= hi; i++)
            tv[i] = '{raw, lvl, rise, 4'h0, any};
    endtask

    function automatic logic [12:0] outs();
        return {btn_level, btn_rise, btn_fall, any_rise};
    endfunction

    initial begin
        // ch0 pressed at v0 -> accepted on the 6th edge (v5).
        // ch1 high 3 cycles (v8..v10) -> rejected; high from v16 -> accepted at v21.
        fill(0,  4,  4'h1, 4'h0, 4'h0, 1'b0);
        fill(5,  5,  4'h1, 4'h1, 4'h1, 1'b1);
        fill(6,  7,  4'h1, 4'h1, 4'h0, 1'b0);
        fill(8,  10, 4'h3, 4'h1, 4'h0, 1'b0);
        fill(11, 15, 4'h1, 4'h1, 4'h0, 1'b0);
        fill(16, 20, 4'h3, 4'h1, 4'h0, 1'b0);
        fill(21, 21, 4'h3, 4'h3, 4'h2, 1'b1);
        fill(22, 23, 4'h3, 4'h3, 4'h0, 1'b0);

        // Reset state
        step(2);
        chk("reset_outs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        step(8);

        // Async reset with all inputs high
        btn_raw = 4'hF;
        step(10);
        chk("pre_reset_level", 32'(btn_level), 32'hF);
        #3 rst_n = 1'b0;
        #1 chk("async_clear", 32'(outs()), 32'h0);
        step(2);
        chk("reset_hold", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        step(5);
        chk("post_reset_e5", 32'(outs()), 32'h0);
        step(1);
        chk("post_reset_e6", 32'(outs()), {19'h0, 4'hF, 4'hF, 4'h0, 1'b1});
        step(1);
        chk("post_reset_e7", 32'(outs()), {19'h0, 4'hF, 4'h0, 4'h0, 1'b0});

        btn_raw = 4'h0;
        step(8);
        chk("all_released", 32'(btn_level), 32'h0);

`ifndef BTN_AUTO_REPEAT_EN
        // Clean press and glitch boundary
        for (int i = 0; i < 24; i++) begin
            btn_raw = tv[i].raw;
            step(1);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tv[i].lvl, tv[i].rise, tv[i].fall, tv[i].any}));
        end

        // Bounce then release on ch2 starting from level 1
        btn_raw = 4'h7;
        step(8);
        chk("bounce_pre", 32'(btn_level), 32'h7);
        for (int k = 0; k < 30; k++) begin
            btn_raw[2] = (k < 20) ? logic'((k / 2) % 2) : 1'b0;
            step(1);
            chk($sformatf("bounce%0d", k), 32'({btn_level[2], btn_rise, btn_fall, any_rise}),
                32'({logic'(k < 25), 4'h0, (k == 25) ? 4'h4 : 4'h0, 1'b0}));
        end

        // ena freeze on ch3: two counting cycles, ten frozen, two more
        btn_raw = 4'hB;
        step(4);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk($sformatf("freeze%0d", k), 32'({btn_level, btn_rise, any_rise}), 32'({4'h3, 4'h0, 1'b0}));
        end
        ena = 1'b1;
        step(1);
        chk("resume1", 32'({btn_level, btn_rise, any_rise}), 32'({4'h3, 4'h0, 1'b0}));
        step(1);
        chk("resume2", 32'({btn_level, btn_rise, any_rise}), 32'({4'hB, 4'h8, 1'b1}));
        step(1);
        chk("resume3", 32'({btn_level, btn_rise, any_rise}), 32'({4'hB, 4'h0, 1'b0}));
`else
        // Auto-repeat on ch0: acceptance, then +8, +11, +14
        begin
            int falls;
            btn_raw = 4'h1;
            step(6);
            chk("rpt_accept", 32'({btn_level[0], btn_rise[0], any_rise}), 32'h7);
            for (int k = 1; k <= 15; k++) begin
                logic p;
                p = (k == 8) || (k == 11) || (k == 14);
                step(1);
                chk($sformatf("rpt%0d", k), 32'({btn_level[0], btn_rise[0], any_rise}), 32'({1'b1, p, p}));
            end
            btn_raw = 4'h0;
            falls = 0;
            for (int k = 0; k < 10; k++) begin
                step(1);
                if (btn_fall[0]) falls++;
            end
            chk("rpt_release_falls", 32'(falls), 32'd1);
            chk("rpt_release_level", 32'(btn_level), 32'h0);
            for (int k = 0; k < 12; k++) begin
                step(1);
                chk($sformatf("rpt_stopped%0d", k), 32'(btn_rise), 32'h0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
